// File: rtl/spi_slave_mem.sv
// SPI mode-0 target: turns 56-bit opcode/address/data frames into single local
// memory writes or reads. Every SPI pin is oversampled on clk.
module spi_slave_mem #(
    parameter int AWIDTH   = 12,
    parameter int DWIDTH   = 32,
    parameter int OP_WIDTH = 8,
    parameter int AFIELD   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              frame_done,
    output logic              frame_err
);
    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WDATA, RDATA, END_WAIT} state_e;

    localparam logic [OP_WIDTH-1:0] OP_WRITE  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_READ   = OP_WIDTH'(3);
    localparam logic [5:0]          OP_LAST   = 6'(OP_WIDTH - 1);
    localparam logic [5:0]          ADDR_LAST = 6'(AFIELD - 1);
    localparam logic [5:0]          DATA_LAST = 6'(DWIDTH - 1);
    localparam logic [5:0]          DATA_BITS = 6'(DWIDTH);

    // [0],[1] are the synchronizer stages, [2] is the previous synchronized value.
    logic [2:0]          sclk_sync_q, sclk_sync_d;
    logic [2:0]          cs_sync_q, cs_sync_d;
    logic [1:0]          mosi_sync_q, mosi_sync_d;
    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DWIDTH-1:0]   rx_q, rx_d;
    logic [DWIDTH-1:0]   tx_q, tx_d;
    logic [AWIDTH-1:0]   frame_addr_q, frame_addr_d;
    logic                is_write_q, is_write_d;
    logic                err_q, err_d;
    logic                load_q, load_d;
    logic                miso_q, miso_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    logic                sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, addr_ok;
    logic [DWIDTH-1:0]   rx_shift;
    logic [OP_WIDTH-1:0] op_word;
    logic [AFIELD-1:0]   addr_word;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[1:0], cs_n};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
        cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
        mosi_s      = mosi_sync_q[1];
        rx_shift    = {rx_q[DWIDTH-2:0], mosi_s};
        op_word     = rx_shift[OP_WIDTH-1:0];
        addr_word   = rx_shift[AFIELD-1:0];
        addr_ok     = (addr_word[AFIELD-1:AWIDTH] == '0) && (addr_word[1:0] == 2'b00);
    end

    // NOTE: every flop uses <= so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            state_q      <= END_WAIT;
            cnt_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            frame_addr_q <= '0;
            is_write_q   <= 1'b0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            miso_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            frame_addr_q <= frame_addr_d;
            is_write_q   <= is_write_d;
            err_q        <= err_d;
            load_q       <= load_d;
            miso_q       <= miso_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
        end
    end

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        frame_addr_d = frame_addr_q;
        is_write_d   = is_write_q;
        err_d        = err_q;
        miso_d       = miso_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        done_d       = 1'b0;
        ferr_d       = 1'b0;
        load_d       = mem_re_q;
        if (load_q) tx_d = mem_rdata;

        // A cs_n rise mid-frame wins over any sclk edge seen in the same cycle.
        if (cs_rise && (state_q != IDLE) && (state_q != END_WAIT)) begin
            state_d = IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d = OPCODE;
                    cnt_d   = '0;
                    rx_d    = '0;
                    err_d   = 1'b0;
                end
                OPCODE: if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == OP_LAST) begin
                        cnt_d = '0;
                        if (op_word == OP_WRITE || op_word == OP_READ) begin
                            state_d    = ADDR;
                            is_write_d = (op_word == OP_WRITE);
                        end else begin
                            state_d = END_WAIT;
                            err_d   = 1'b1;
                        end
                    end
                end
                ADDR: if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d        = '0;
                        frame_addr_d = addr_word[AWIDTH-1:0];
                        if (!addr_ok) begin
                            state_d = END_WAIT;
                            err_d   = 1'b1;
                        end else if (is_write_q) begin
                            state_d = WDATA;
                        end else begin
                            state_d    = RDATA;
                            mem_re_d   = 1'b1;
                            mem_addr_d = addr_word[AWIDTH-1:0];
                            miso_d     = 1'b0;
                        end
                    end
                end
                WDATA: if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d       = '0;
                        state_d     = END_WAIT;
                        mem_we_d    = 1'b1;
                        done_d      = 1'b1;
                        mem_addr_d  = frame_addr_q;
                        mem_wdata_d = rx_shift;
                    end
                end
                // The first fall presents bit 31; the fall after bit 0 was presented closes the frame.
                RDATA: if (sclk_fall) begin
                    if (cnt_q == DATA_BITS) begin
                        cnt_d   = '0;
                        state_d = END_WAIT;
                        done_d  = 1'b1;
                    end else begin
                        miso_d = tx_q[DWIDTH-1];
                        tx_d   = {tx_q[DWIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
                END_WAIT: if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ferr_d  = err_q;
                    err_d   = 1'b0;
                end
                default: state_d = END_WAIT;
            endcase
        end
    end

    always_comb begin
        miso_oe = (state_q == RDATA);
        miso    = miso_oe & miso_q;
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bench for spi_slave_mem: a bit-banging SPI master, a 1-cycle-latency memory,
// and a frame-level model predicting strobes, pulses and read-back data.
module tb_spi_slave_mem;
    localparam int AWIDTH = 12;
    localparam int DWIDTH = 32;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk  = 1'b0;
    logic              cs_n  = 1'b1;
    logic              mosi  = 1'b0;
    logic              miso, miso_oe, mem_we, mem_re, frame_done, frame_err;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [AWIDTH-1:0] we_addr = '0, re_addr = '0;
    logic [DWIDTH-1:0] we_data = '0;
    logic oe_window = 1'b0;

    logic [31:0] ram [0:1023];
    bit          ram_vld [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit          ref_vld [0:1023];

    spi_slave_mem dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [9:0] idx);
        if (idx == 10'd4) return 32'hA5A50F0F;
        return 32'(32'h9E3779B9 * (32'(idx) + 32'd1));
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] idx);
        return ref_vld[idx] ? ref_mem[idx] : init_word(idx);
    endfunction

    // Memory behind the DUT: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[11:2]]     <= mem_wdata;
            ram_vld[mem_addr[11:2]] <= 1'b1;
        end
        if (mem_re)
            mem_rdata <= ram_vld[mem_addr[11:2]] ? ram[mem_addr[11:2]] : init_word(mem_addr[11:2]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: strobes counted and timed, output gating checked.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
                check("we_latency", 64'(cyc - rise_cyc), 64'd3);
                check("we_with_done", 64'(frame_done), 64'd1);
            end
            if (mem_re) begin
                re_cnt++;
                re_addr = mem_addr;
                check("re_latency", 64'(cyc - rise_cyc), 64'd3);
            end
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            check("miso_gated", 64'(miso & ~miso_oe), 64'd0);
            check("oe_window", 64'(miso_oe & ~oe_window), 64'd0);
            check("strobe_excl", 64'(mem_we & mem_re), 64'd0);
            check("addr_align", 64'(mem_addr[1:0]), 64'd0);
        end
    end

    task automatic do_frame(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] data,
                            input int nbits, input int rst_at, output logic [31:0] rx);
        logic [55:0] bits;
        logic        legal_rd;
        bits     = {op, addr, data};
        legal_rd = (op == 8'h03) && (addr[15:12] == 4'h0) && (addr[1:0] == 2'b00);
        rx       = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_outputs_zero",
                      64'({miso, miso_oe, mem_we, mem_re, frame_done, frame_err, mem_addr, mem_wdata}), 64'd0);
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
            end
            mosi = bits[55-i];
            if (i == 23 && legal_rd) oe_window = 1'b1;
            repeat (8) @(negedge clk);
            rise_cyc = cyc;
            sclk     = 1'b1;
            if (i >= 24) rx = {rx[30:0], miso};
            if (i >= 24 && legal_rd && rst_at < 0 && nbits == 56)
                check("oe_data_phase", 64'(miso_oe), 64'd1);
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        oe_window = 1'b0;
    endtask

    // Frame-level model: outcome depends only on opcode, address legality and bit count.
    task automatic run_frame(input string name, input logic [7:0] op, input logic [15:0] addr,
                             input logic [31:0] data, input int nbits, input int rst_at,
                             output logic [31:0] rx);
        int   we0, re0, done0, err0, eff;
        logic legal, complete, rd_issued;
        we0 = we_cnt; re0 = re_cnt; done0 = done_cnt; err0 = err_cnt;
        do_frame(op, addr, data, nbits, rst_at, rx);
        legal     = ((op == 8'h02) || (op == 8'h03)) && (addr[15:12] == 4'h0) && (addr[1:0] == 2'b00);
        eff       = (rst_at >= 0) ? rst_at : nbits;
        complete  = legal && (rst_at < 0) && (nbits == 56);
        rd_issued = (op == 8'h03) && legal && (eff >= 24);
        check($sformatf("%s we_count", name), 64'(we_cnt - we0), 64'((op == 8'h02 && complete) ? 1 : 0));
        check($sformatf("%s re_count", name), 64'(re_cnt - re0), 64'(rd_issued ? 1 : 0));
        check($sformatf("%s done_count", name), 64'(done_cnt - done0), 64'(complete ? 1 : 0));
        check($sformatf("%s err_count", name), 64'(err_cnt - err0), 64'((rst_at < 0 && !complete) ? 1 : 0));
        if (op == 8'h02 && complete) begin
            check($sformatf("%s we_addr", name), 64'(we_addr), 64'(addr[11:0]));
            check($sformatf("%s we_data", name), 64'(we_data), 64'(data));
            check($sformatf("%s addr_held", name), 64'(mem_addr), 64'(addr[11:0]));
            check($sformatf("%s wdata_held", name), 64'(mem_wdata), 64'(data));
            ref_mem[addr[11:2]] = data;
            ref_vld[addr[11:2]] = 1'b1;
        end
        if (rd_issued) check($sformatf("%s re_addr", name), 64'(re_addr), 64'(addr[11:0]));
        if (op == 8'h03 && complete)
            check($sformatf("%s read_data", name), 64'(rx), 64'(ref_word(addr[11:2])));
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  op;
        logic [15:0] addr;
        logic [31:0] data;
        int          kind, nb;

        repeat (3) @(negedge clk);
        check("reset_state",
              64'({miso, miso_oe, mem_we, mem_re, frame_done, frame_err, mem_addr, mem_wdata}), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_frame("rd_init", 8'h03, 16'h0010, 32'h0, 56, -1, rx);
        check("rd_init literal", 64'(rx), 64'h0000_0000_A5A5_0F0F);
        run_frame("wr_dead", 8'h02, 16'h0010, 32'hDEADBEEF, 56, -1, rx);
        check("wr_dead literal addr", 64'(we_addr), 64'h010);
        check("wr_dead literal data", 64'(we_data), 64'h0000_0000_DEAD_BEEF);
        run_frame("rd_back", 8'h03, 16'h0010, 32'h0, 56, -1, rx);
        check("rd_back literal", 64'(rx), 64'h0000_0000_DEAD_BEEF);
        run_frame("bad_op", 8'h55, 16'h0010, 32'h1234_5678, 56, -1, rx);
        run_frame("bad_range", 8'h02, 16'h1000, 32'h1111_1111, 56, -1, rx);
        run_frame("bad_align", 8'h02, 16'h0013, 32'h2222_2222, 56, -1, rx);
        run_frame("abort_wr", 8'h02, 16'h0020, 32'h3333_3333, 44, -1, rx);
        run_frame("wr_ffc", 8'h02, 16'h0FFC, 32'h12345678, 56, -1, rx);
        check("wr_ffc literal addr", 64'(mem_addr), 64'hFFC);
        run_frame("rst_rd", 8'h03, 16'h0FFC, 32'h0, 56, 30, rx);
        run_frame("rd_ffc", 8'h03, 16'h0FFC, 32'h0, 56, -1, rx);
        check("rd_ffc literal", 64'(rx), 64'h0000_0000_1234_5678);

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 5));
            data = $urandom;
            addr = {4'h0, ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 7))
                                                     : 10'($urandom_range(1016, 1023)), 2'b00};
            op   = (kind < 2) ? 8'h02 : 8'h03;
            nb   = 56;
            if (kind == 4) begin
                if ($urandom_range(0, 1) != 0) begin
                    op = 8'($urandom_range(4, 255));
                end else begin
                    addr = 16'($urandom);
                    if (addr[15:12] == 4'h0 && addr[1:0] == 2'b00) addr[0] = 1'b1;
                end
            end else if (kind == 5) begin
                nb = int'($urandom_range(1, 55));
            end
            run_frame($sformatf("rand%0d", n), op, addr, data, nb, -1, rx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
